// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state encodings, lamp codes and lamp selection helper
package traffic_pkg;

    // Encodings are visible on the state output, so the values are fixed.
    typedef enum logic [2:0] {
        RED   = 3'd0,
        GRN   = 3'd1,
        YEL   = 3'd2,
        EMG   = 3'd3,
        FLASH = 3'd4
    } state_t;

    // Lamp head codes, {R,Y,G}
    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // One approach's lamp given whether it is green now and in the phase that follows.
    // Green in both keeps green through the change, green only now shows yellow.
    // Calling with both arguments equal gives the plain green/red decode.
    function automatic logic [2:0] lamp_sel(input logic grn_now, input logic grn_next);
        if (grn_now && grn_next)
            return LAMP_G;
        else if (grn_now)
            return LAMP_Y;
        else
            return LAMP_R;
    endfunction

endpackage

// File: rtl/traffic_if.sv
// rtl/traffic_if.sv - configuration, request and lamp signals between the sequencer and its user
//
// master: the side that supplies timing/masks/requests and observes the lamps
// slave : the sequencer (traffic_phase_ctrl)
//   grn_time   NUM_PHASE*CNT_W     green ticks of phase p at [p*CNT_W +: CNT_W]
//   grn_mask   NUM_PHASE*NUM_APPR  bit a of phase p set = approach a green in phase p
//   night_mode 1                   request flashing mode
//   emerg_req  1                   emergency pre-emption request
//   emerg_ph   PH_W                phase forced green during emergency
//   lights     NUM_APPR*3          per approach {R,Y,G}
//   phase      PH_W                current phase index
//   state      3                   RED=0 GRN=1 YEL=2 EMG=3 FLASH=4
//   count      CNT_W               ticks remaining in the interval, minus 1
//   tick       1                   one-cycle tick strobe
interface traffic_if #(
    parameter int NUM_APPR  = 4,
    parameter int NUM_PHASE = 6,
    parameter int CNT_W     = 8
);
    localparam int PH_W = $clog2(NUM_PHASE);

    logic [NUM_PHASE*CNT_W-1:0]    grn_time;
    logic [NUM_PHASE*NUM_APPR-1:0] grn_mask;
    logic                          night_mode;
    logic                          emerg_req;
    logic [PH_W-1:0]               emerg_ph;
    logic [NUM_APPR*3-1:0]         lights;
    logic [PH_W-1:0]               phase;
    logic [2:0]                    state;
    logic [CNT_W-1:0]              count;
    logic                          tick;

    modport master (
        output grn_time, grn_mask, night_mode, emerg_req, emerg_ph,
        input  lights, phase, state, count, tick
    );

    modport slave (
        input  grn_time, grn_mask, night_mode, emerg_req, emerg_ph,
        output lights, phase, state, count, tick
    );

endinterface

// File: rtl/traffic_tick_gen.sv
// rtl/traffic_tick_gen.sv - prescaler producing a one-cycle tick every TICK_DIV clocks
//
//   clk   in   clock
//   rst   in   reset, asynchronous, active-high
//   tick  out  registered strobe, high for one cycle each time the prescaler wraps
module traffic_tick_gen #(
    parameter int TICK_DIV = 50
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre;

    // With TICK_DIV=1 the prescaler sits at 0 and tick stays high after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre  <= '0;
            tick <= 1'b0;
        end else if (pre == LAST) begin
            pre  <= '0;
            tick <= 1'b1;
        end else begin
            pre  <= pre + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - multi-approach traffic phase sequencer with emergency and night modes
//
//   clk   in   clock
//   rst   in   reset, asynchronous, active-high
//   bus   slave side of traffic_if: timing/mask/request inputs, lamp/phase/state/count/tick outputs
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_APPR  = 4,
    parameter int NUM_PHASE = 6,
    parameter int CNT_W     = 8,
    parameter int TICK_DIV  = 50,
    parameter int YEL_TICKS = 2,
    parameter int RED_TICKS = 1
) (
    input  logic     clk,
    input  logic     rst,
    traffic_if.slave bus
);
    localparam int PH_W = $clog2(NUM_PHASE);
    localparam int LW   = NUM_APPR * 3;

    localparam logic [PH_W-1:0]  LAST_PH  = PH_W'(NUM_PHASE - 1);
    localparam logic [CNT_W-1:0] YEL_LOAD = CNT_W'(YEL_TICKS - 1);
    localparam logic [CNT_W-1:0] RED_LOAD = CNT_W'(RED_TICKS - 1);
    localparam logic [LW-1:0]    ALL_RED  = {NUM_APPR{LAMP_R}};
    localparam logic [LW-1:0]    ALL_YEL  = {NUM_APPR{LAMP_Y}};
    localparam logic [LW-1:0]    ALL_OFF  = {NUM_APPR{LAMP_OFF}};

    logic             tick;
    state_t           st;
    logic [PH_W-1:0]  ph;
    logic [CNT_W-1:0] cnt;
    logic [LW-1:0]    lamps;

    traffic_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Next-phase selection, green masks and precomputed lamp patterns for every
    // transition, so the FSM only picks which pattern to register.
    logic [PH_W-1:0]     ph_next;
    logic [NUM_APPR-1:0] mask_cur;
    logic [NUM_APPR-1:0] mask_next;
    logic [NUM_APPR-1:0] mask_emg;
    logic [CNT_W-1:0]    grn_raw;
    logic [CNT_W-1:0]    grn_load;
    logic [LW-1:0]       lamps_grn_next;
    logic [LW-1:0]       lamps_yel_norm;
    logic [LW-1:0]       lamps_yel_emg;
    logic [LW-1:0]       lamps_emg;

    always_comb begin
        ph_next        = (ph == LAST_PH) ? '0 : ph + 1'b1;
        mask_cur       = bus.grn_mask[int'(ph) * NUM_APPR +: NUM_APPR];
        mask_next      = bus.grn_mask[int'(ph_next) * NUM_APPR +: NUM_APPR];
        mask_emg       = bus.grn_mask[int'(bus.emerg_ph) * NUM_APPR +: NUM_APPR];
        grn_raw        = bus.grn_time[int'(ph_next) * CNT_W +: CNT_W];
        // A programmed green of 0 would underflow the counter; run it as 1 tick.
        grn_load       = (grn_raw == '0) ? '0 : grn_raw - 1'b1;
        lamps_grn_next = '0;
        lamps_yel_norm = '0;
        lamps_yel_emg  = '0;
        lamps_emg      = '0;
        for (int a = 0; a < NUM_APPR; a++) begin
            lamps_grn_next[a*3 +: 3] = lamp_sel(mask_next[a], mask_next[a]);
            lamps_yel_norm[a*3 +: 3] = lamp_sel(mask_cur[a], mask_next[a]);
            lamps_yel_emg[a*3 +: 3]  = lamp_sel(mask_cur[a], mask_emg[a]);
            lamps_emg[a*3 +: 3]      = lamp_sel(mask_emg[a], mask_emg[a]);
        end
    end

    // Phase sequencer. Every register moves only on tick cycles; lamps are
    // registered alongside state and phase so all outputs change together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st    <= RED;
            ph    <= LAST_PH;
            cnt   <= RED_LOAD;
            lamps <= ALL_RED;
        end else if (tick) begin
            unique case (st)
                GRN: begin
                    if (bus.emerg_req && (ph == bus.emerg_ph)) begin
                        // Already showing the emergency phase: no clearance needed.
                        st    <= EMG;
                        lamps <= lamps_emg;
                    end else if (bus.emerg_req || (cnt == '0)) begin
                        // Yellow is computed against where the sequence is going,
                        // which during pre-emption is the emergency phase.
                        st    <= YEL;
                        cnt   <= YEL_LOAD;
                        lamps <= bus.emerg_req ? lamps_yel_emg : lamps_yel_norm;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                YEL: begin
                    if (cnt == '0) begin
                        st    <= RED;
                        cnt   <= RED_LOAD;
                        lamps <= ALL_RED;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RED: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (bus.emerg_req) begin
                        st    <= EMG;
                        ph    <= bus.emerg_ph;
                        lamps <= lamps_emg;
                    end else if (bus.night_mode) begin
                        st    <= FLASH;
                        lamps <= ALL_YEL;
                    end else begin
                        st    <= GRN;
                        ph    <= ph_next;
                        cnt   <= grn_load;
                        lamps <= lamps_grn_next;
                    end
                end
                EMG: begin
                    if (!bus.emerg_req) begin
                        // Phase stays at emerg_ph so the next green is the one after it.
                        st    <= RED;
                        cnt   <= RED_LOAD;
                        lamps <= ALL_RED;
                    end else begin
                        // Follows emerg_ph changes directly, without a yellow.
                        ph    <= bus.emerg_ph;
                        lamps <= lamps_emg;
                    end
                end
                FLASH: begin
                    if (bus.emerg_req || !bus.night_mode) begin
                        // Restart the cycle at phase 0 after the clearance red.
                        st    <= RED;
                        ph    <= LAST_PH;
                        cnt   <= RED_LOAD;
                        lamps <= ALL_RED;
                    end else begin
                        lamps <= (lamps == ALL_YEL) ? ALL_OFF : ALL_YEL;
                    end
                end
                default: begin
                    st    <= RED;
                    ph    <= LAST_PH;
                    cnt   <= RED_LOAD;
                    lamps <= ALL_RED;
                end
            endcase
        end
    end

    assign bus.state  = st;
    assign bus.phase  = ph;
    assign bus.count  = cnt;
    assign bus.lights = lamps;
    assign bus.tick   = tick;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb/tb_traffic_phase_ctrl.sv - directed self-checking bench for traffic_phase_ctrl
module tb_traffic_phase_ctrl;

    localparam logic [2:0] S_RED = 3'd0, S_GRN = 3'd1, S_YEL = 3'd2, S_EMG = 3'd3, S_FLASH = 3'd4;

    localparam logic [23:0] T_NORM  = {8'd5, 8'd3, 8'd7};       // p2=5 p1=3 p0=7
    localparam logic [23:0] T_ZERO0 = {8'd5, 8'd3, 8'd0};
    localparam logic [11:0] M_NORM  = {4'b1000, 4'b0100, 4'b0011};
    localparam logic [11:0] M_OVL   = {4'b1000, 4'b0010, 4'b0011};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    traffic_if #(.NUM_APPR(4), .NUM_PHASE(3), .CNT_W(8)) bus ();

    traffic_phase_ctrl #(
        .NUM_APPR(4), .NUM_PHASE(3), .CNT_W(8),
        .TICK_DIV(1), .YEL_TICKS(2), .RED_TICKS(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [2:0] st, input logic [1:0] ph,
                       input logic [11:0] lt, input logic [7:0] cn);
        n_vec++;
        assert ({bus.state, bus.phase, bus.lights, bus.count} === {st, ph, lt, cn}) else begin
            n_err++;
            $error("FAIL %s: got st=%0d ph=%0d lights=%h cnt=%0d, want st=%0d ph=%0d lights=%h cnt=%0d",
                   tag, bus.state, bus.phase, bus.lights, bus.count, st, ph, lt, cn);
        end
    endtask

    task automatic chk_tick(input string tag, input logic exp);
        n_vec++;
        assert (bus.tick === exp) else begin
            n_err++;
            $error("FAIL %s: got tick=%b, want tick=%b", tag, bus.tick, exp);
        end
    endtask

    // n consecutive tick intervals of one state; count either counts down from c0 or holds.
    task automatic run(input string tag, input logic [2:0] st, input logic [1:0] ph,
                       input logic [11:0] lt, input int c0, input int n, input bit dec);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s[%0d]", tag, i), st, ph, lt, 8'(dec ? c0 - i : c0));
            step();
        end
    endtask

    // Leaves the bench at the negedge just before the first FSM tick after reset.
    task automatic do_reset(input string tag);
        rst = 1'b1;
        step();
        step();
        chk({tag, "_rst"}, S_RED, 2'd2, 12'h924, 8'd0);
        chk_tick({tag, "_rst_tick"}, 1'b0);
        rst = 1'b0;
        step();
        chk({tag, "_rel"}, S_RED, 2'd2, 12'h924, 8'd0);
        chk_tick({tag, "_rel_tick"}, 1'b1);
    endtask

    initial begin
        bus.grn_time   = T_NORM;
        bus.grn_mask   = M_NORM;
        bus.night_mode = 1'b0;
        bus.emerg_req  = 1'b0;
        bus.emerg_ph   = 2'd0;

        // Normal cycle: 7+3+5 green plus 3 x (2 yellow + 1 red) = 24 ticks.
        do_reset("norm");
        step();
        run("n_g0", S_GRN, 2'd0, 12'h909, 6, 7, 1'b1);
        run("n_y0", S_YEL, 2'd0, 12'h912, 1, 2, 1'b1);
        run("n_r0", S_RED, 2'd0, 12'h924, 0, 1, 1'b1);
        run("n_g1", S_GRN, 2'd1, 12'h864, 2, 3, 1'b1);
        run("n_y1", S_YEL, 2'd1, 12'h8A4, 1, 2, 1'b1);
        run("n_r1", S_RED, 2'd1, 12'h924, 0, 1, 1'b1);
        run("n_g2", S_GRN, 2'd2, 12'h324, 4, 5, 1'b1);
        run("n_y2", S_YEL, 2'd2, 12'h524, 1, 2, 1'b1);
        run("n_r2", S_RED, 2'd2, 12'h924, 0, 1, 1'b1);
        chk("n_wrap", S_GRN, 2'd0, 12'h909, 8'd6);

        // Overlap: approach 1 green in p0 and p1 stays green through yellow.
        bus.grn_mask = M_OVL;
        do_reset("ovl");
        step();
        run("o_g0", S_GRN, 2'd0, 12'h909, 6, 7, 1'b1);
        run("o_y0", S_YEL, 2'd0, 12'h90A, 1, 2, 1'b1);
        run("o_r0", S_RED, 2'd0, 12'h924, 0, 1, 1'b1);
        chk("o_g1", S_GRN, 2'd1, 12'h90C, 8'd2);

        // Emergency pre-emption towards phase 2, then direct entry and emerg_ph change.
        bus.grn_mask = M_NORM;
        do_reset("emg");
        step();
        chk("e_g0", S_GRN, 2'd0, 12'h909, 8'd6);
        bus.emerg_ph  = 2'd2;
        bus.emerg_req = 1'b1;
        step();
        run("e_y0", S_YEL, 2'd0, 12'h912, 1, 2, 1'b1);
        run("e_r0", S_RED, 2'd0, 12'h924, 0, 1, 1'b1);
        run("e_emg", S_EMG, 2'd2, 12'h324, 0, 3, 1'b0);
        bus.emerg_req = 1'b0;
        step();
        chk("e_exit_red", S_RED, 2'd2, 12'h924, 8'd0);
        step();
        chk("e_resume", S_GRN, 2'd0, 12'h909, 8'd6);
        bus.emerg_ph  = 2'd0;
        bus.emerg_req = 1'b1;
        step();
        chk("e_direct", S_EMG, 2'd0, 12'h909, 8'd6);
        bus.emerg_ph = 2'd1;
        step();
        chk("e_phchg", S_EMG, 2'd1, 12'h864, 8'd6);
        bus.emerg_req = 1'b0;
        step();
        chk("e_red2", S_RED, 2'd1, 12'h924, 8'd0);
        step();
        chk("e_g2", S_GRN, 2'd2, 12'h324, 8'd4);

        // Night mode requested mid-green: finish the phase, then flash; leave via red to phase 0.
        do_reset("ngt");
        step();
        chk("g_g0", S_GRN, 2'd0, 12'h909, 8'd6);
        bus.night_mode = 1'b1;
        step();
        run("g_g0b", S_GRN, 2'd0, 12'h909, 5, 6, 1'b1);
        run("g_y0", S_YEL, 2'd0, 12'h912, 1, 2, 1'b1);
        run("g_r0", S_RED, 2'd0, 12'h924, 0, 1, 1'b1);
        chk("g_fl_on", S_FLASH, 2'd0, 12'h492, 8'd0);
        step();
        chk("g_fl_off", S_FLASH, 2'd0, 12'h000, 8'd0);
        step();
        chk("g_fl_on2", S_FLASH, 2'd0, 12'h492, 8'd0);
        bus.night_mode = 1'b0;
        step();
        chk("g_exit_red", S_RED, 2'd2, 12'h924, 8'd0);
        step();
        chk("g_g0_again", S_GRN, 2'd0, 12'h909, 8'd6);

        // Night already requested at reset, then emergency from flash.
        bus.night_mode = 1'b1;
        do_reset("fle");
        step();
        chk("f_on", S_FLASH, 2'd2, 12'h492, 8'd0);
        step();
        chk("f_off", S_FLASH, 2'd2, 12'h000, 8'd0);
        bus.emerg_ph  = 2'd1;
        bus.emerg_req = 1'b1;
        step();
        chk("f_red", S_RED, 2'd2, 12'h924, 8'd0);
        step();
        chk("f_emg", S_EMG, 2'd1, 12'h864, 8'd0);
        bus.emerg_req  = 1'b0;
        bus.night_mode = 1'b0;
        step();
        chk("f_exit_red", S_RED, 2'd1, 12'h924, 8'd0);
        step();
        chk("f_g2", S_GRN, 2'd2, 12'h324, 8'd4);

        // Zero green time on phase 0 runs as a single tick.
        bus.grn_time = T_ZERO0;
        do_reset("zero");
        step();
        chk("z_g0", S_GRN, 2'd0, 12'h909, 8'd0);
        step();
        chk("z_y0", S_YEL, 2'd0, 12'h912, 8'd1);

        // Asynchronous reset during yellow clears lamps without waiting for a clock edge.
        bus.grn_time = T_NORM;
        do_reset("ry");
        step();
        run("r_g0", S_GRN, 2'd0, 12'h909, 6, 7, 1'b1);
        chk("r_y0", S_YEL, 2'd0, 12'h912, 8'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("r_async", S_RED, 2'd2, 12'h924, 8'd0);
        do_reset("ry2");
        step();
        chk("r_first_g", S_GRN, 2'd0, 12'h909, 8'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
